hazard_ctrl: RTL

Pipeline hazard controller for the five-stage RV32I core. It consumes the destination-address stream carried by the inter-stage segment registers (reg_dest_EX/MEM/WB, csr_dest_MEM/WB) together with source addresses and control events. From these it drives every segment register's bubble/flush pair, the ALU and CSR operand forwarding selects, and a data-cache miss stall FSM with performance and watchdog counters.

---
 rtl/hazard_ctrl_pkg.sv | 23 ++
 rtl/hazard_ctrl_fwd_sel.sv | 32 +++
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  // Data-cache miss handling states.
  typedef enum logic {
    RUN,
    MISS_WAIT
  } state_t;

  // Operand source encodings shared by the ALU and CSR forwarding selects.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Width of the performance and watchdog counters.
  localparam int CNT_W = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding source select: compares one source address against the MEM and WB
// destinations and picks the youngest matching producer.
module fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int W         = 5,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic [W-1:0] src,
  input  logic [W-1:0] dest_mem,
  input  logic         write_en_mem,
  input  logic [W-1:0] dest_wb,
  input  logic         write_en_wb,
  output logic [1:0]   sel
);

  logic hit_mem;
  logic hit_wb;

  // Register x0 is hardwired to zero, so a write to it must never be forwarded;
  // CSR address 0 is an ordinary register and opts out via SKIP_ZERO.
  assign hit_mem = write_en_mem && (dest_mem == src) && !(SKIP_ZERO && (dest_mem == '0));
  assign hit_wb  = write_en_wb  && (dest_wb  == src) && !(SKIP_ZERO && (dest_wb  == '0));

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    sel = FWD_RF;
    if (hit_mem)     sel = FWD_MEM;
    else if (hit_wb) sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage bubble/flush controls, operand forwarding
// selects, and the data-cache miss freeze FSM with its counters and watchdog.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MISS_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       reg1_src_ID,
  input  logic [4:0]       reg2_src_ID,
  input  logic [4:0]       reg1_src_EX,
  input  logic [4:0]       reg2_src_EX,
  input  logic [4:0]       reg_dest_EX,
  input  logic [4:0]       reg_dest_MEM,
  input  logic [4:0]       reg_dest_WB,
  input  logic             reg_write_en_MEM,
  input  logic             reg_write_en_WB,
  input  logic             mem_read_EX,
  input  logic [11:0]      csr_src_EX,
  input  logic [11:0]      csr_dest_MEM,
  input  logic [11:0]      csr_dest_WB,
  input  logic             csr_write_en_MEM,
  input  logic             csr_write_en_WB,
  input  logic             br_taken_EX,
  input  logic             jalr_EX,
  input  logic             jal_ID,
  input  logic             dcache_miss,
  input  logic             dcache_done,
  output logic             bubbleF,
  output logic             flushF,
  output logic             bubbleD,
  output logic             flushD,
  output logic             bubbleE,
  output logic             flushE,
  output logic             bubbleM,
  output logic             flushM,
  output logic             bubbleW,
  output logic             flushW,
  output logic [1:0]       op1_sel,
  output logic [1:0]       op2_sel,
  output logic [1:0]       csr_sel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] miss_count,
  output logic             miss_timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MISS_TIMEOUT);

  state_t           state;
  state_t           next_state;
  logic             freeze;
  logic             redirect;
  logic             load_use;
  logic             load_use_stall;
  logic [CNT_W-1:0] wait_cnt;

  assign redirect = br_taken_EX || jalr_EX;
  assign load_use = mem_read_EX && (reg_dest_EX != 5'd0) &&
                    ((reg_dest_EX == reg1_src_ID) || (reg_dest_EX == reg2_src_ID));

  // A load-use stall only takes effect when nothing of higher priority wins.
  assign load_use_stall = load_use && !rst && !freeze && !redirect;

  // Miss FSM next state; freeze covers the miss cycle itself and every wait cycle.
  always_comb begin
    next_state = state;
    freeze     = 1'b0;
    case (state)
      RUN: begin
        if (dcache_miss && !dcache_done) begin
          next_state = MISS_WAIT;
          freeze     = 1'b1;
        end
      end
      MISS_WAIT: begin
        if (dcache_done) next_state = RUN;
        else             freeze     = 1'b1;
      end
      default: next_state = RUN;
    endcase
  end

  // Stage controls in priority order: reset, freeze, redirect, load-use, jal.
  always_comb begin
    bubbleF = 1'b0;
    flushF  = 1'b0;
    bubbleD = 1'b0;
    flushD  = 1'b0;
    bubbleE = 1'b0;
    flushE  = 1'b0;
    bubbleM = 1'b0;
    flushM  = 1'b0;
    bubbleW = 1'b0;
    flushW  = 1'b0;
    if (rst) begin
      flushF = 1'b1;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (freeze) begin
      bubbleF = 1'b1;
      bubbleD = 1'b1;
      bubbleE = 1'b1;
      bubbleM = 1'b1;
      flushW  = 1'b1;
    end else if (redirect) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (load_use) begin
      bubbleF = 1'b1;
      bubbleD = 1'b1;
      flushE  = 1'b1;
    end else if (jal_ID) begin
      flushD = 1'b1;
    end
  end

  fwd_sel #(.W(5), .SKIP_ZERO(1'b1)) u_fwd_op1 (
    .src          (reg1_src_EX),
    .dest_mem     (reg_dest_MEM),
    .write_en_mem (reg_write_en_MEM),
    .dest_wb      (reg_dest_WB),
    .write_en_wb  (reg_write_en_WB),
    .sel          (op1_sel)
  );

  fwd_sel #(.W(5), .SKIP_ZERO(1'b1)) u_fwd_op2 (
    .src          (reg2_src_EX),
    .dest_mem     (reg_dest_MEM),
    .write_en_mem (reg_write_en_MEM),
    .dest_wb      (reg_dest_WB),
    .write_en_wb  (reg_write_en_WB),
    .sel          (op2_sel)
  );

  fwd_sel #(.W(12), .SKIP_ZERO(1'b0)) u_fwd_csr (
    .src          (csr_src_EX),
    .dest_mem     (csr_dest_MEM),
    .write_en_mem (csr_write_en_MEM),
    .dest_wb      (csr_dest_WB),
    .write_en_wb  (csr_write_en_WB),
    .sel          (csr_sel)
  );

  // Miss FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  // Stall/miss counters and the miss watchdog, which flags but never ends the freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      miss_count   <= '0;
      wait_cnt     <= '0;
      miss_timeout <= 1'b0;
    end else begin
      if (freeze || load_use_stall) stall_cycles <= sat_inc(stall_cycles);
      if (state == RUN && next_state == MISS_WAIT) begin
        miss_count <= sat_inc(miss_count);
        wait_cnt   <= '0;
      end else if (state == MISS_WAIT) begin
        if (wait_cnt != TIMEOUT_VAL) wait_cnt <= wait_cnt + CNT_W'(1);
        if (wait_cnt >= TIMEOUT_VAL - CNT_W'(1)) miss_timeout <= 1'b1;
      end
    end
  end

endmodule
